// File: rtl/cls_text_feed_fsm.sv
// cls_text_feed_fsm: latches two 16-char lines and sequences clear/line1/line2 strobes to the PMOD CLS driver.
// Define CLS_FEED_CLEAR_EACH_REDRAW_EN to issue a clear before every redraw, not only after reset.
module cls_text_feed_fsm #(
  parameter int parm_fast_simulation = 0,
  parameter int FCLK_ce = 2500000,
  parameter int P_REFRESH_MS = 1000
) (
  input  logic         i_ext_spi_clk_x,
  input  logic         i_srst,
  input  logic         i_spi_ce_4x,
  input  logic         i_cls_command_ready,
  output logic         o_cls_wr_clear_display,
  output logic         o_cls_wr_text_line1,
  output logic         o_cls_wr_text_line2,
  output logic [127:0] o_cls_txt_ascii_line1,
  output logic [127:0] o_cls_txt_ascii_line2,
  input  logic [127:0] i_dat_ascii_line1,
  input  logic [127:0] i_dat_ascii_line2,
  input  logic         i_dat_update,
  output logic         o_busy
);
  localparam logic [3:0] ST_FEED_BOOT    = 4'd0;
  localparam logic [3:0] ST_FEED_CLR_CMD = 4'd1;
  localparam logic [3:0] ST_FEED_CLR_ACK = 4'd2;
  localparam logic [3:0] ST_FEED_SNAP    = 4'd3;
  localparam logic [3:0] ST_FEED_L1_CMD  = 4'd4;
  localparam logic [3:0] ST_FEED_L1_ACK  = 4'd5;
  localparam logic [3:0] ST_FEED_L2_CMD  = 4'd6;
  localparam logic [3:0] ST_FEED_L2_ACK  = 4'd7;
  localparam logic [3:0] ST_FEED_IDLE    = 4'd8;
  localparam int c_full = FCLK_ce / 1000 * P_REFRESH_MS;
  localparam logic [23:0] c_refresh = 24'((parm_fast_simulation != 0) ? c_full / 100 : c_full);
`ifdef CLS_FEED_CLEAR_EACH_REDRAW_EN
  localparam logic [3:0] ST_REDRAW = ST_FEED_CLR_CMD;
`else
  localparam logic [3:0] ST_REDRAW = ST_FEED_SNAP;
`endif

  logic [3:0]   state_q, state_d;
  logic [23:0]  tmr_q;
  logic [1:0]   ack_q;
  logic         pend_q;
  logic         clr_q, l1_q, l2_q, clr_d, l1_d, l2_d;
  logic [127:0] txt1_q, txt2_q;
  logic         rdy, lost, tmo, is_ack;

  assign rdy    = i_cls_command_ready;
  // ready still high on the fourth ACK cycle means the driver never took the command
  assign lost   = (ack_q == 2'd3) && rdy;
  assign tmo    = tmr_q == c_refresh - 24'd1;
  assign is_ack = (state_q == ST_FEED_CLR_ACK) || (state_q == ST_FEED_L1_ACK) || (state_q == ST_FEED_L2_ACK);

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    l1_d    = 1'b0;
    l2_d    = 1'b0;
    case (state_q)
      ST_FEED_BOOT:    state_d = rdy ? ST_FEED_CLR_CMD : ST_FEED_BOOT;
      ST_FEED_CLR_CMD: begin
        clr_d   = rdy;
        state_d = rdy ? ST_FEED_CLR_ACK : ST_FEED_CLR_CMD;
      end
      ST_FEED_CLR_ACK: state_d = !rdy ? ST_FEED_SNAP : lost ? ST_FEED_CLR_CMD : ST_FEED_CLR_ACK;
      ST_FEED_SNAP:    state_d = ST_FEED_L1_CMD;
      ST_FEED_L1_CMD:  begin
        l1_d    = rdy;
        state_d = rdy ? ST_FEED_L1_ACK : ST_FEED_L1_CMD;
      end
      ST_FEED_L1_ACK:  state_d = !rdy ? ST_FEED_L2_CMD : lost ? ST_FEED_L1_CMD : ST_FEED_L1_ACK;
      ST_FEED_L2_CMD:  begin
        l2_d    = rdy;
        state_d = rdy ? ST_FEED_L2_ACK : ST_FEED_L2_CMD;
      end
      ST_FEED_L2_ACK:  state_d = !rdy ? ST_FEED_IDLE : lost ? ST_FEED_L2_CMD : ST_FEED_L2_ACK;
      ST_FEED_IDLE:    state_d = (pend_q || tmo) ? ST_REDRAW : ST_FEED_IDLE;
      default:         state_d = ST_FEED_BOOT;
    endcase
  end

  always_ff @(posedge i_ext_spi_clk_x) begin
    if (i_srst) begin
      state_q <= ST_FEED_BOOT;
      tmr_q   <= '0;
      ack_q   <= '0;
      pend_q  <= 1'b0;
      clr_q   <= 1'b0;
      l1_q    <= 1'b0;
      l2_q    <= 1'b0;
      txt1_q  <= {16{8'h20}};
      txt2_q  <= {16{8'h20}};
    end else if (i_spi_ce_4x) begin
      state_q <= state_d;
      clr_q   <= clr_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      tmr_q   <= (state_d != state_q) ? '0 : (state_q == ST_FEED_IDLE) ? tmr_q + 24'd1 : tmr_q;
      ack_q   <= (is_ack && state_d == state_q) ? ack_q + 2'd1 : 2'd0;
      // an update landing on the SNAP entry edge must not be lost, so set wins over clear
      pend_q  <= i_dat_update ? 1'b1 : (state_d == ST_FEED_SNAP && state_q != ST_FEED_SNAP) ? 1'b0 : pend_q;
      if (state_q == ST_FEED_SNAP) begin
        txt1_q <= i_dat_ascii_line1;
        txt2_q <= i_dat_ascii_line2;
      end
    end
  end

  assign o_cls_wr_clear_display = clr_q;
  assign o_cls_wr_text_line1    = l1_q;
  assign o_cls_wr_text_line2    = l2_q;
  assign o_cls_txt_ascii_line1  = txt1_q;
  assign o_cls_txt_ascii_line2  = txt2_q;
  assign o_busy                 = state_q != ST_FEED_IDLE;
endmodule
